// File: rtl/tt_bist_harness_if.sv
// Control/status and DUT-facing bus for the BIST harness.
// The harness takes the slave modport; the controlling side takes the master modport.
interface tt_bist_harness_if #(
    parameter int STIM_W = 8,
    parameter int RESP_W = 8,
    parameter int CNT_W  = 9
);
    logic              start;
    logic              abort;
    logic [STIM_W-1:0] stim_o;
    logic [RESP_W-1:0] resp_i;
    logic [RESP_W-1:0] exp_sig_i;
    logic              busy;
    logic              done;
    logic              pass;
    logic [RESP_W-1:0] sig_o;
    logic [CNT_W-1:0]  vec_cnt_o;

    modport master (
        output start, abort, resp_i, exp_sig_i,
        input  stim_o, busy, done, pass, sig_o, vec_cnt_o
    );
    modport slave (
        input  start, abort, resp_i, exp_sig_i,
        output stim_o, busy, done, pass, sig_o, vec_cnt_o
    );
endinterface

// File: rtl/tt_bist_harness.sv
// LFSR-stimulus / MISR-signature BIST harness.
// A delay line on the stimulus-valid bit re-aligns capture with a pipelined DUT.
module tt_bist_harness #(
    parameter int                STIM_W    = 8,
    parameter int                RESP_W    = 8,
    parameter int                N_VECTORS = 256,
    parameter int                LATENCY   = 0,
    parameter logic [STIM_W-1:0] SEED      = 'h01,
    parameter logic [STIM_W-1:0] LFSR_TAPS = 'hB8,
    parameter logic [RESP_W-1:0] MISR_POLY = 'h1D
) (
    input logic            clk,
    input logic            rst,
    tt_bist_harness_if.slave bus
);
    localparam int CNT_W = $clog2(N_VECTORS + 1);
    // An all-zero seed would lock the LFSR at zero forever.
    localparam logic [STIM_W-1:0] SEED_EFF = (SEED == '0) ? STIM_W'(1) : SEED;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [STIM_W-1:0] r_stim, w_lfsr_nxt;
    logic [RESP_W-1:0] r_sig, w_sig_nxt;
    logic [CNT_W-1:0]  r_vec;
    logic [3:0]        r_drain;
    logic              r_pass;
    logic              w_go, w_abort, w_last_vec, w_run, w_cap_en;
    logic [LATENCY:0]  w_vld_pipe;

    assign w_run      = (r_state == S_RUN);
    assign w_abort    = bus.abort && (r_state == S_RUN || r_state == S_DRAIN);
    assign w_go       = bus.start && !bus.abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_vec = w_run && (r_vec == CNT_W'(N_VECTORS));
    assign w_lfsr_nxt = (r_stim >> 1) ^ (r_stim[0] ? LFSR_TAPS : '0);
    assign w_sig_nxt  = {r_sig[RESP_W-2:0], 1'b0} ^ (r_sig[RESP_W-1] ? MISR_POLY : '0) ^ bus.resp_i;

    generate
        if (LATENCY > 0) begin : g_dly
            logic [LATENCY-1:0] r_vld_sh;
            assign w_vld_pipe = {r_vld_sh, w_run};
            always_ff @(posedge clk) begin
                if (rst || w_abort || w_go) r_vld_sh <= '0;
                else                        r_vld_sh <= w_vld_pipe[LATENCY-1:0];
            end
        end else begin : g_nodly
            assign w_vld_pipe = w_run;
        end
    endgenerate

    assign w_cap_en = w_vld_pipe[LATENCY] && !w_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_abort)         w_state_nxt = S_IDLE;
                else if (w_last_vec) w_state_nxt = (LATENCY > 0) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                if (w_abort)           w_state_nxt = S_IDLE;
                else if (r_drain == 0) w_state_nxt = S_DONE;
            end
            S_DONE:  if (w_go) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stim  <= '0;
            r_sig   <= '0;
            r_vec   <= '0;
            r_drain <= '0;
            r_pass  <= 1'b0;
        end else if (w_go) begin
            r_stim <= SEED_EFF;
            r_sig  <= '0;
            r_vec  <= CNT_W'(1);
            r_pass <= 1'b0;
        end else if (w_abort) begin
            r_stim <= '0;
            r_vec  <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_cap_en) r_sig <= w_sig_nxt;
            if (w_run && !w_last_vec) begin
                r_stim <= w_lfsr_nxt;
                if (r_vec < CNT_W'(N_VECTORS)) r_vec <= r_vec + 1'b1;
            end
            if (w_last_vec)
                r_drain <= 4'((LATENCY > 0) ? LATENCY - 1 : 0);
            else if (r_state == S_DRAIN && r_drain != 0)
                r_drain <= r_drain - 1'b1;
            // The final capture lands on the same edge as DONE entry, so compare the next signature.
            if (w_state_nxt == S_DONE && r_state != S_DONE)
                r_pass <= ((w_cap_en ? w_sig_nxt : r_sig) == bus.exp_sig_i);
        end
    end

    assign bus.stim_o    = r_stim;
    assign bus.sig_o     = r_sig;
    assign bus.vec_cnt_o = r_vec;
    assign bus.busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = r_pass && (r_state == S_DONE);
endmodule

// File: tb/tb_tt_bist_harness.sv
// Scoreboard bench: a zero-latency loopback harness and a 2-stage-pipe harness run side by side.
module tb_tt_bist_harness;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_bist_harness_if #(.STIM_W(8), .RESP_W(8), .CNT_W(3)) if0 ();
    tt_bist_harness_if #(.STIM_W(8), .RESP_W(8), .CNT_W(3)) if2 ();

    logic       r_zero;
    logic [7:0] r_p1, r_p2;
    logic [7:0] q_stim[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign if0.resp_i = r_zero ? 8'h00 : if0.stim_o;
    always_ff @(posedge clk) begin
        r_p1 <= if2.stim_o;
        r_p2 <= r_p1;
    end
    assign if2.resp_i = r_p2;
    assign if2.start  = if0.start;
    assign if2.abort  = if0.abort;

    tt_bist_harness #(.N_VECTORS(4), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    tt_bist_harness #(.N_VECTORS(4), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_f(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [7:0] misr_f(input logic [7:0] sig, input logic [7:0] r);
        return {sig[6:0], 1'b0} ^ (sig[7] ? 8'h1D : 8'h00) ^ r;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, ".stim"}, if0.stim_o, 0);
        chk({tag, ".sig"},  if0.sig_o, 0);
        chk({tag, ".vec"},  if0.vec_cnt_o, 0);
        chk({tag, ".busy"}, if0.busy, 0);
        chk({tag, ".done"}, if0.done, 0);
        chk({tag, ".pass"}, if0.pass, 0);
        chk({tag, ".busy2"}, if2.busy, 0);
        chk({tag, ".done2"}, if2.done, 0);
    endtask

    // Pushes the expected stimulus stream and drives one run; extra_start re-pulses start mid-run.
    task automatic run(input string tag, input logic zero, input int extra_start,
                       input logic [7:0] x0, input logic [7:0] x2);
        logic [7:0] s, e0, e2;
        int t0, t2, b0, b2;
        r_zero = zero;
        if0.exp_sig_i = x0;
        if2.exp_sig_i = x2;
        s = 8'h01; e0 = 8'h00; e2 = 8'h00;
        for (int i = 0; i < 4; i++) begin
            q_stim.push_back(s);
            e0 = misr_f(e0, zero ? 8'h00 : s);
            e2 = misr_f(e2, s);
            s  = lfsr_f(s);
        end
        if0.start = 1'b1;
        t0 = 0; t2 = 0; b0 = 0; b2 = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if0.start = (cyc == extra_start);
            if (if0.busy) begin
                b0++;
                if (q_stim.size() > 0) chk({tag, ".stim"}, if0.stim_o, q_stim.pop_front());
                else                   chk({tag, ".extra_vec"}, 1, 0);
            end
            if (if2.busy) b2++;
            if (if0.done && t0 == 0) t0 = cyc;
            if (if2.done && t2 == 0) t2 = cyc;
            if (t0 != 0 && t2 != 0) break;
        end
        if0.start = 1'b0;
        chk({tag, ".done_t0"}, t0, 5);
        chk({tag, ".done_t2"}, t2, 7);
        chk({tag, ".busy0"}, b0, 4);
        chk({tag, ".busy2"}, b2, 6);
        chk({tag, ".q_left"}, q_stim.size(), 0);
        q_stim.delete();
        chk({tag, ".sig0"}, if0.sig_o, e0);
        chk({tag, ".sig2"}, if2.sig_o, e2);
        chk({tag, ".pass0"}, if0.pass, (e0 == x0));
        chk({tag, ".pass2"}, if2.pass, (e2 == x2));
        chk({tag, ".vec0"}, if0.vec_cnt_o, 4);
        chk({tag, ".vec2"}, if2.vec_cnt_o, 4);
    endtask

    initial begin
        rst = 1'b1;
        if0.start = 1'b0;
        if0.abort = 1'b0;
        if0.exp_sig_i = 8'h00;
        if2.exp_sig_i = 8'h00;
        r_zero = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Loopback, both latencies
        run("t1", 1'b0, 0, 8'h44, 8'h44);
        chk("t1.sig_golden", if0.sig_o, 8'h44);
        chk("t2.sig_golden", if2.sig_o, 8'h44);

        // Golden changes while DONE: pass is latched
        if0.exp_sig_i = 8'h45;
        @(negedge clk);
        chk("t1.pass_held", if0.pass, 1);
        chk("t1.done_held", if0.done, 1);

        // Restart from DONE with a mismatching golden; a mid-run start is ignored
        run("t6", 1'b0, 2, 8'h45, 8'h44);

        // Response tied to zero
        run("t3", 1'b1, 0, 8'h00, 8'h44);

        // Abort in the 2nd RUN cycle
        r_zero = 1'b0;
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        @(negedge clk);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        chk("t4.busy", if0.busy, 0);
        chk("t4.done", if0.done, 0);
        chk("t4.stim", if0.stim_o, 0);
        chk("t4.vec", if0.vec_cnt_o, 0);
        chk("t4.busy2", if2.busy, 0);
        @(negedge clk);
        run("t4", 1'b0, 0, 8'h44, 8'h44);

        // Reset in the 3rd RUN cycle with start held high
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        if0.start = 1'b1;
        @(negedge clk);
        chk_reset("t5");
        rst = 1'b0;
        if0.start = 1'b0;
        @(negedge clk);
        chk("t5.idle_busy", if0.busy, 0);
        chk("t5.idle_vec", if0.vec_cnt_o, 0);
        run("t5", 1'b0, 0, 8'h44, 8'h44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
